// File: rtl/sfifo_rd_pkg.sv
// Shared constants for the sfifo read-side controller: skid depth, occupancy
// encoding, statistics width and the pop-credit rule.
package sfifo_rd_pkg;

  localparam int SKID      = 2;
  localparam int POP_CNT_W = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // A pop may be issued only if every word already committed to the skid
  // (held + in flight - leaving now) still leaves room for one more.
  function automatic logic has_credit(input logic [1:0] cnt,
                                      input logic       inflight,
                                      input logic       fire);
    logic [2:0] committed;
    committed = {1'b0, cnt} + {2'b00, inflight} - {2'b00, fire};
    return committed < 3'(SKID);
  endfunction

endpackage

// File: rtl/sfifo_reader_if.sv
// FIFO pop port plus downstream valid/ready stream of the sfifo reader.
// master = the reader itself, slave = the FIFO and downstream consumer side.
interface sfifo_reader_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_r_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_r_en, m_valid, m_data
  );

endinterface

// File: rtl/sfifo_rd_skid.sv
// Two-entry skid buffer: tail written by wr_i, head released by rd_i,
// 1-bit head/tail pointers wrapping modulo 2, occupancy exported as cnt_o.
module sfifo_rd_skid
  import sfifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       cnt_o
);

  logic [WIDTH-1:0] mem_q [SKID];
  logic             head_q;
  logic             tail_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;

  // NOTE: cnt_d gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_i, rd_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the two data slots are reset so the head reads 0 after reset; a
  // deeper storage array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID; i++) mem_q[i] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= ST_EMPTY;
    end else begin
      if (wr_i) begin
        mem_q[tail_q] <= wr_data_i;
        tail_q        <= ~tail_q;
      end
      if (rd_i) head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign cnt_o       = cnt_q;

  // The credit rule guarantees a full buffer never sees a capture.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_i && cnt_q == ST_TWO));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_i && cnt_q == ST_EMPTY));

endmodule

// File: rtl/sfifo_reader.sv
// Read-side controller for sfifo: credit-based pops into a 2-entry skid buffer
// re-presented as valid/ready. Define SFIFO_READER_STATS_EN for pop_count.
module sfifo_reader
  import sfifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sfifo_reader_if.master       bus
`ifdef SFIFO_READER_STATS_EN
  ,
  output logic [POP_CNT_W-1:0] pop_count
`endif
);

  logic       inflight_q;
  logic [1:0] cnt;
  logic       fire;
  logic       r_en;

  assign bus.m_valid = (cnt != ST_EMPTY);
  assign fire        = bus.m_valid & bus.m_ready;

  // Combinational in m_ready: a word leaving this cycle frees a slot now.
  assign r_en          = rst_n & ~bus.fifo_empty & has_credit(cnt, inflight_q, fire);
  assign bus.fifo_r_en = r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= r_en;
  end

  sfifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_i        (inflight_q),
    .wr_data_i   (bus.fifo_dout),
    .rd_i        (fire),
    .head_data_o (bus.m_data),
    .cnt_o       (cnt)
  );

`ifdef SFIFO_READER_STATS_EN
  logic [POP_CNT_W-1:0] pop_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pop_count_q <= '0;
    else if (fire) pop_count_q <= pop_count_q + 1'b1;
  end

  assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_sfifo_reader.sv
// Bench for sfifo_reader behind a behavioural 4-deep sfifo with 1-cycle read
// latency; a scoreboard queue holds pushed words, a monitor checks deliveries.
module tb_sfifo_reader;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfifo_reader_if #(.WIDTH(W)) bus ();

`ifdef SFIFO_READER_STATS_EN
  logic [15:0] pop_count;
`endif

  sfifo_reader #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef SFIFO_READER_STATS_EN
    ,
    .pop_count (pop_count)
`endif
  );

  // ---------------- behavioural sfifo ----------------
  logic         push_en = 1'b0;
  logic [W-1:0] push_data = '0;
  logic [W-1:0] fq[$];
  int           fifo_count;
  int           popped;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      bus.fifo_empty <= 1'b1;
      bus.fifo_dout  <= '0;
      fifo_count     <= 0;
      popped         <= 0;
    end else begin
      if (bus.fifo_r_en && fq.size() != 0) begin
        bus.fifo_dout <= fq.pop_front();
        popped        <= popped + 1;
      end
      if (push_en && fq.size() < DEPTH) fq.push_back(push_data);
      bus.fifo_empty <= (fq.size() == 0);
      fifo_count     <= fq.size();
    end
  end

  // ---------------- scoreboard and bookkeeping ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fired = 0;
  int first_ren = -1;
  int first_valid = -1;
  int first_fire = -1;
  int last_fire = -1;
  logic         held = 1'b0;
  logic [W-1:0] held_data = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, far from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_empty) check("no_ren_when_empty", {31'b0, bus.fifo_r_en}, 32'd0);
      if (bus.fifo_r_en && first_ren < 0) first_ren = cyc;
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (held) begin
        check("hold_valid", {31'b0, bus.m_valid}, 32'd1);
        check("hold_data", {24'b0, bus.m_data}, {24'b0, held_data});
      end
      held      = bus.m_valid && !bus.m_ready;
      held_data = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_fire", {24'b0, bus.m_data}, 32'hFFFF_FFFF);
        end else begin
          check("order", {24'b0, bus.m_data}, {24'b0, exp_q.pop_front()});
        end
        fired++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      check("skid_occupancy_le2", {31'b0, (popped - fired) <= 2}, 32'd1);
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    exp_q.push_back(d);
    step();
    push_en = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic clear_marks();
    first_ren = -1; first_valid = -1; first_fire = -1; last_fire = -1;
  endtask

  initial begin
    logic [W-1:0] seq [4];
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
    check("rst_m_data", {24'b0, bus.m_data}, 32'd0);
    check("rst_r_en", {31'b0, bus.fifo_r_en}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // 1. Streaming with m_ready=1: back-to-back delivery, 2-cycle latency
    clear_marks();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(seq[i]);
    wait_drained(50);
    check("latency_ren_to_valid", first_valid - first_ren, 32'd2);
    check("back_to_back", last_fire - first_fire, 32'd3);

    // 2. Stalled downstream: exactly two pops, head held
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(seq[i]);
    repeat (6) step();
    @(negedge clk);
    check("stall_fifo_count", fifo_count, 32'd2);
    check("stall_r_en", {31'b0, bus.fifo_r_en}, 32'd0);
    check("stall_m_valid", {31'b0, bus.m_valid}, 32'd1);
    check("stall_head", {24'b0, bus.m_data}, 32'hA1);
    check("stall_skid_full", popped - fired, 32'd2);

    // 3. Toggling ready drains in order
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      step();
      bus.m_ready = ~bus.m_ready;
    end
    bus.m_ready = 1'b1;
    wait_drained(20);

    // 4. Idle with ready high, then a single word
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_r_en", {31'b0, bus.fifo_r_en}, 32'd0);
      check("idle_m_valid", {31'b0, bus.m_valid}, 32'd0);
    end
    step();
    push(8'hE5);
    wait_drained(20);
    repeat (5) step();

    // 5. Async reset mid-stream with a full skid and words still queued
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(seq[i] ^ 8'h5A);
    repeat (4) step();
    check("pre_reset_skid_full", popped - fired, 32'd2);
    rst_n = 1'b0;
    #1;
    check("reset_m_valid", {31'b0, bus.m_valid}, 32'd0);
    check("reset_r_en", {31'b0, bus.fifo_r_en}, 32'd0);
    exp_q.delete();
    fired = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.m_ready = 1'b1;
    push(8'hF6);
    wait_drained(20);
    repeat (5) step();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.m_ready = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1 && fifo_count + (push_en ? 1 : 0) < DEPTH - 1) begin
        push(W'($urandom));
      end else begin
        step();
      end
    end
    bus.m_ready = 1'b1;
    wait_drained(50);

`ifdef SFIFO_READER_STATS_EN
    // 6. Statistics counter: counts fires since reset, wraps at 0xFFFF
    @(negedge clk);
    check("pop_count_total", {16'b0, pop_count}, fired & 32'hFFFF);
    bus.m_ready = 1'b0;
    step();
    force dut.pop_count_q = 16'hFFFF;
    step();
    release dut.pop_count_q;
    bus.m_ready = 1'b1;
    push(8'h77);
    wait_drained(20);
    @(negedge clk);
    check("pop_count_wrap", {16'b0, pop_count}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
